// File: rtl/v65c02_bus_pkg.sv
// System memory map and shared bus types for the 65C02 address decoder.
package v65c02_bus_pkg;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int MAP_SLAVES = 4;

  localparam logic [DATA_W-1:0] UNMAPPED_DATA = 8'h00;

  // Slave 0 in the LSBs: RAM $0000-$7FFF, IO $8xxx, VIA $90xx, ROM $C000-$FFFF
  localparam logic [MAP_SLAVES*ADDR_W-1:0] MAP_BASE = 64'hC000_9000_8000_0000;
  localparam logic [MAP_SLAVES*ADDR_W-1:0] MAP_MASK = 64'hC000_FF00_F000_8000;
  localparam logic [4*MAP_SLAVES-1:0]      MAP_WAIT = 16'h0200;
  localparam logic [MAP_SLAVES-1:0]        MAP_WP   = 4'b1000;

  typedef enum logic {ST_IDLE, ST_WAIT} bus_state_e;
endpackage

// File: rtl/bus_region_match.sv
// Hit detect for one base/mask region; mask bits set to 1 are compared.
module bus_region_match #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] mask_i,
  output logic              hit_o
);
  assign hit_o = ((addr_i ^ base_i) & mask_i) == '0;
endmodule

// File: rtl/mem_bus_decoder.sv
// Address decoder with per-region wait states, write protect, read mux and sticky error.
module mem_bus_decoder #(
  parameter int                          NUM_SLAVES    = v65c02_bus_pkg::MAP_SLAVES,
  parameter int                          ADDR_W        = v65c02_bus_pkg::ADDR_W,
  parameter int                          DATA_W        = v65c02_bus_pkg::DATA_W,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE   = v65c02_bus_pkg::MAP_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK   = v65c02_bus_pkg::MAP_MASK,
  parameter logic [4*NUM_SLAVES-1:0]     SLAVE_WAIT    = v65c02_bus_pkg::MAP_WAIT,
  parameter logic [NUM_SLAVES-1:0]       SLAVE_WP      = v65c02_bus_pkg::MAP_WP,
  parameter logic [DATA_W-1:0]           UNMAPPED_DATA = v65c02_bus_pkg::UNMAPPED_DATA
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_W-1:0]            cpu_addr_i,
  input  logic                         cpu_we_i,
  output logic                         cpu_rdy_o,
  output logic [DATA_W-1:0]            cpu_din_o,
  output logic [NUM_SLAVES-1:0]        slave_en_o,
  output logic                         slave_we_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] slave_dout_i,
  input  logic                         err_clr_i,
  output logic                         bus_err_o
);
  import v65c02_bus_pkg::*;

  localparam int IDX_W = $clog2(NUM_SLAVES + 1);
  localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(NUM_SLAVES);

  bus_state_e        state_q;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  sel_q;
  logic              err_q, err_d, err_set;
  logic [NUM_SLAVES-1:0] hit;
  logic [IDX_W-1:0]  win;
  logic              mapped, win_wp;
  logic [3:0]        win_k;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
    bus_region_match #(.ADDR_W(ADDR_W)) u_match (
      .addr_i (cpu_addr_i),
      .base_i (SLAVE_BASE[g*ADDR_W +: ADDR_W]),
      .mask_i (SLAVE_MASK[g*ADDR_W +: ADDR_W]),
      .hit_o  (hit[g])
    );
  end

  // Scan high to low so the lowest hitting index is the last one written.
  always_comb begin
    win = IDX_NONE;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (hit[i]) win = IDX_W'(i);
    mapped = (win != IDX_NONE);
    win_k  = 4'd0;
    win_wp = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (win == IDX_W'(i)) begin
        win_k  = SLAVE_WAIT[4*i +: 4];
        win_wp = SLAVE_WP[i];
      end
  end

  always_comb begin
    cpu_rdy_o = 1'b1;
    if (!rst_i) begin
      if (state_q == ST_WAIT) cpu_rdy_o = (cnt_q == 4'd0);
      else                    cpu_rdy_o = !mapped || (win_k == 4'd0);
    end
    slave_en_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      slave_en_o[i] = !rst_i && (win == IDX_W'(i));
    slave_we_o = !rst_i && cpu_we_i && cpu_rdy_o && mapped && !win_wp;
    err_set    = !rst_i && cpu_rdy_o && (!mapped || (cpu_we_i && win_wp));
    err_d      = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= IDX_NONE;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (mapped && win_k != 4'd0) begin
            state_q <= ST_WAIT;
            cnt_q   <= win_k - 4'd1;
          end
        ST_WAIT:
          if (cnt_q == 4'd0) state_q <= ST_IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        default: state_q <= ST_IDLE;
      endcase
      if (cpu_rdy_o) sel_q <= win;
      err_q <= err_d;
    end
  end

  always_comb begin
    cpu_din_o = UNMAPPED_DATA;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel_q == IDX_W'(i)) cpu_din_o = slave_dout_i[i*DATA_W +: DATA_W];
  end

  assign bus_err_o = err_q;
endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed and random accesses against a transaction-level model of the decoder.
module tb_mem_bus_decoder;
  import v65c02_bus_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst = 1'b1;
  logic [ADDR_W-1:0]              cpu_addr = '0;
  logic                           cpu_we = 1'b0;
  logic                           rdy;
  logic [DATA_W-1:0]              din;
  logic [MAP_SLAVES-1:0]          en;
  logic                           swe;
  logic [MAP_SLAVES*DATA_W-1:0]   slave_dout = '0;
  logic                           err_clr = 1'b0;
  logic                           err;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  mem_bus_decoder dut (
    .clk_i(clk), .rst_i(rst), .cpu_addr_i(cpu_addr), .cpu_we_i(cpu_we),
    .cpu_rdy_o(rdy), .cpu_din_o(din), .slave_en_o(en), .slave_we_o(swe),
    .slave_dout_i(slave_dout), .err_clr_i(err_clr), .bus_err_o(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First region (lowest index) whose masked base matches; MAP_SLAVES if none.
  function automatic int ref_decode(input logic [15:0] addr);
    logic [63:0] base, mask;
    base = MAP_BASE;
    mask = MAP_MASK;
    for (int i = 0; i < MAP_SLAVES; i++)
      if ((addr & mask[i*16 +: 16]) == (base[i*16 +: 16] & mask[i*16 +: 16])) return i;
    return MAP_SLAVES;
  endfunction

  // One complete CPU access; err_clr (if requested) is pulsed in the ready cycle.
  task automatic do_access(input string tag, input logic [15:0] addr, input logic we,
                           input logic clr, input logic [31:0] lanes);
    int idx, k;
    logic wp, mapped, set_err;
    logic [15:0] waits;
    logic [3:0] wps, exp_en;
    logic [7:0] exp_din;
    waits  = MAP_WAIT;
    wps    = MAP_WP;
    idx    = ref_decode(addr);
    mapped = (idx < MAP_SLAVES);
    k      = mapped ? int'((waits >> (4*idx)) & 16'hF) : 0;
    wp     = mapped ? wps[idx] : 1'b0;
    exp_en = mapped ? 4'(1 << idx) : 4'b0;
    cpu_addr = addr; cpu_we = we; slave_dout = lanes; err_clr = 1'b0;
    for (int c = 0; c <= k; c++) begin
      if (c == k) err_clr = clr;
      @(negedge clk);
      check({tag, ".rdy"}, 32'(rdy), 32'(c == k));
      check({tag, ".en"},  32'(en), 32'(exp_en));
      check({tag, ".we"},  32'(swe), 32'((c == k) && we && mapped && !wp));
      @(posedge clk); #1;
    end
    err_clr = 1'b0;
    set_err = !mapped || (we && wp);
    m_err   = set_err ? 1'b1 : (clr ? 1'b0 : m_err);
    exp_din = mapped ? lanes[idx*8 +: 8] : UNMAPPED_DATA;
    check({tag, ".din"}, 32'(din), 32'(exp_din));
    check({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  initial begin
    logic [15:0] a;
    // Reset state
    @(posedge clk); #1;
    cpu_addr = 16'h9004;
    @(negedge clk);
    check("rst.rdy", 32'(rdy), 32'd1);
    check("rst.en",  32'(en), 32'd0);
    check("rst.we",  32'(swe), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst.din", 32'(din), 32'(UNMAPPED_DATA));
    check("rst.err", 32'(err), 32'd0);

    do_access("rd0123", 16'h0123, 1'b0, 1'b0, 32'h1122_335A);
    do_access("rd9004", 16'h9004, 1'b0, 1'b0, 32'h44A7_6677);
    do_access("wr9004", 16'h9004, 1'b1, 1'b0, 32'h0);
    do_access("wrC010", 16'hC010, 1'b1, 1'b0, 32'h0);
    do_access("hold",   16'h0123, 1'b0, 1'b0, 32'h0000_00E1);
    do_access("clr",    16'h0123, 1'b0, 1'b1, 32'h0000_00E2);
    do_access("rdA000", 16'hA000, 1'b0, 1'b0, 32'hFFFF_FFFF);
    do_access("clrset", 16'hA000, 1'b0, 1'b1, 32'hFFFF_FFFF);
    do_access("rd8000", 16'h8000, 1'b0, 1'b1, 32'h00C3_0000);

    // Reset during the first wait cycle aborts the count and clears state
    do_access("wrFFFE", 16'hFFFE, 1'b1, 1'b0, 32'h0);
    cpu_addr = 16'h9004; cpu_we = 1'b0;
    @(negedge clk);
    check("mid.rdy0", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid.rdy", 32'(rdy), 32'd1);
    check("mid.en",  32'(en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_err = 1'b0;
    check("mid.din", 32'(din), 32'(UNMAPPED_DATA));
    check("mid.err", 32'(err), 32'd0);
    do_access("postrst", 16'h0123, 1'b0, 1'b0, 32'h0000_0099);

    // Random accesses biased toward each region
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0: a = 16'($urandom_range(0, 16'h7FFF));
        1: a = 16'h8000 | 16'($urandom_range(0, 16'h0FFF));
        2: a = 16'h9000 | 16'($urandom_range(0, 16'h00FF));
        3: a = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
        default: a = 16'($urandom);
      endcase
      do_access("rnd", a, 1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_bus_decoder.md
MEM_BUS_DECODER -- requirements
Module: mem_bus_decoder

Interface
REQ-001 The block SHALL take parameter NUM_SLAVES, default 4: number of decoded regions, legal range 1..8.
REQ-002 The block SHALL take parameter ADDR_W, default 16: CPU address width.
REQ-003 The block SHALL take parameter DATA_W, default 8: data width.
REQ-004 The block SHALL take parameter SLAVE_BASE, default 64'h C000_9000_8000_0000: flattened per-slave base, ADDR_W bits per slave, slave 0 in the LSBs.
REQ-005 The block SHALL take parameter SLAVE_MASK, default 64'h C000_FF00_F000_8000: flattened per-slave compare mask; a 1 bit is compared.
REQ-006 The block SHALL take parameter SLAVE_WAIT, default 16'h0200: 4 bits per slave, giving wait states 0..15.
REQ-007 The block SHALL take parameter SLAVE_WP, default 4'b1000: per-slave write-protect bit.
REQ-008 The block SHALL take parameter UNMAPPED_DATA, default 8'h00: data returned on an unmapped read.
REQ-009 Port clk_i: input, 1 bit, the single clock.
REQ-010 Port rst_i: input, 1 bit, reset; synchronous, active-high.
REQ-011 Port cpu_addr_i: input, ADDR_W bits, CPU address.
REQ-012 Port cpu_we_i: input, 1 bit, CPU write enable.
REQ-013 Port cpu_rdy_o: output, 1 bit, ready to the CPU; when low, the CPU holds its address and data.
REQ-014 Port cpu_din_o: output, DATA_W bits, read data to the CPU.
REQ-015 Port slave_en_o: output, NUM_SLAVES bits, one-hot slave enable.
REQ-016 Port slave_we_o: output, 1 bit, qualified write strobe.
REQ-017 Port slave_dout_i: input, NUM_SLAVES*DATA_W bits, flattened slave read data.
REQ-018 Port err_clr_i: input, 1 bit, clears bus_err_o.
REQ-019 Port bus_err_o: output, 1 bit, sticky error flag.

Function
REQ-020 Slave i SHALL hit when (cpu_addr_i & MASK_i) == (BASE_i & MASK_i).
- On overlapping hits, the lowest index wins.
- With no hit, the access is unmapped.
REQ-021 slave_en_o SHALL be combinational from cpu_addr_i in the address cycle, and SHALL hold while cpu_rdy_o is low.
REQ-022 The FSM SHALL have two states, IDLE and WAIT, with a 4-bit counter cnt.
REQ-023 In IDLE, cpu_rdy_o SHALL be 1 if the winning slave's wait count k is 0 or the access is unmapped, and 0 otherwise.
REQ-024 In IDLE with k>0, the FSM SHALL move to WAIT with cnt=k-1.
REQ-025 In WAIT, cpu_rdy_o SHALL equal (cnt==0).
- When cnt!=0, cnt SHALL decrement each cycle.
- When cnt==0, the FSM SHALL return to IDLE.
- Net effect: exactly k low cycles, then one high cycle.
REQ-026 slave_we_o SHALL be asserted only when all of these hold: cpu_we_i, cpu_rdy_o=1, the access is mapped, and the winner is not write-protected. This gives exactly one strobe per write.
REQ-027 A registered select index (log2(NUM_SLAVES+1) bits, value NUM_SLAVES meaning unmapped) SHALL update only in cycles with cpu_rdy_o=1.
REQ-028 cpu_din_o SHALL be the slave_dout_i lane chosen by the registered index, or UNMAPPED_DATA for index NUM_SLAVES. Read latency is one cycle after the rdy-high cycle.
REQ-029 bus_err_o SHALL set on a write to a write-protected slave, and on any unmapped access, in the rdy-high cycle.
REQ-030 err_clr_i SHALL clear bus_err_o; if clear and a set occur in the same cycle, set wins.
REQ-031 An address change while in WAIT is a protocol violation.
- The count SHALL still complete.
- Decode SHALL follow the current address.
REQ-032 NUM_SLAVES=1 SHALL be legal, with a 1-bit index.

Reset
REQ-033 When rst_i is high, on the next clock edge: state=IDLE, cnt=0, select index=NUM_SLAVES, bus_err_o=0.
REQ-034 While rst_i is high: slave_en_o=0, slave_we_o=0, cpu_rdy_o=1.
- cpu_din_o SHALL equal UNMAPPED_DATA from the first cycle after reset.
- A reset taken mid-WAIT SHALL abort the wait count.

Structure
REQ-035 A shared package v65c02_bus_pkg SHALL hold ADDR_W, DATA_W, UNMAPPED_DATA and the system memory-map base/mask/wait/WP constants; top level and testbench SHALL import it.
REQ-036 One sub-module, bus_region_match, SHALL be instantiated per slave. It returns the hit bit for one base/mask pair.
- A priority encoder, the FSM and the read mux SHALL live in mem_bus_decoder.

Verification (default parameters)
REQ-037 Read $0123 with lane0=8'h5A: slave_en_o=0001 and rdy=1 in cycle n; cpu_din_o=8'h5A in n+1.
REQ-038 Read $9004 (slave2, k=2): rdy low in n and n+1, high in n+2; cpu_din_o equals lane2 in n+3; no bus_err.
REQ-039 Write $9004: slave_we_o is high in exactly one cycle (n+2).
REQ-040 Write $C010: slave_en_o=1000, slave_we_o stays 0, bus_err_o=1 and stays set until err_clr_i is pulsed.
REQ-041 Read $A000 (unmapped): slave_en_o=0, rdy=1, cpu_din_o=8'h00 in n+1, bus_err_o=1.
- Then pulse err_clr_i alongside a second unmapped access in the same cycle: bus_err_o stays 1.
REQ-042 Assert rst_i during the first WAIT cycle of a $9004 read: next cycle shows rdy=1, state IDLE, cpu_din_o=8'h00, bus_err_o=0.
